// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared encodings for the multicycle ARM control unit
package arm_ctrl_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH    = ST_FETCH,
        S_DECODE   = ST_DECODE,
        S_MEMADR   = ST_MEMADR,
        S_MEMREAD  = ST_MEMREAD,
        S_MEMWB    = ST_MEMWB,
        S_MEMWRITE = ST_MEMWRITE,
        S_EXECUTER = ST_EXECUTER,
        S_EXECUTEI = ST_EXECUTEI,
        S_ALUWB    = ST_ALUWB,
        S_BRANCH   = ST_BRANCH
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - instruction fields in, control strobes and selects out
interface multicycle_control_fsm_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;
    logic       NextPC;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;

    modport master (
        output Op, Funct, Rd,
        input  PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );

    modport slave (
        input  Op, Funct, Rd,
        output PCS, RegW, MemW, FlagW, NextPC, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );

endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - ALU operation and flag-write decode; CMP handling under CMP_SUPPORT_EN
module alu_decoder
    import arm_ctrl_pkg::*;
(
    input  logic       ALUOp,
    input  logic [4:0] Funct,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW
);

    logic is_cmp;

    always_comb begin
        ALUControl = ALU_ADD;
        FlagW      = 2'b00;
        is_cmp     = 1'b0;
        if (ALUOp) begin
            case (Funct[4:1])
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
`ifdef CMP_SUPPORT_EN
                CMD_CMP: begin
                    ALUControl = ALU_SUB;
                    is_cmp     = 1'b1;
                end
`endif
                default: ALUControl = ALU_ADD;
            endcase
            // Carry/overflow only mean something for the arithmetic ops.
            FlagW[1] = Funct[0];
            FlagW[0] = Funct[0] & ((ALUControl == ALU_ADD) || (ALUControl == ALU_SUB));
            if (is_cmp) begin
                FlagW = 2'b11;
            end
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore main controller for the multicycle ARM datapath; CMP_SUPPORT_EN enables CMP decode
module multicycle_control_fsm
    import arm_ctrl_pkg::*;
(
    input  logic                           CLK,
    input  logic                           RST_N,
    multicycle_control_fsm_if.slave        ctrl
);

    state_e state_q, state_d;
    logic   alu_op;
    logic   branch;
    logic   reg_w;
    logic   ir_write;
    logic   next_pc;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = S_FETCH;
        alu_op            = 1'b0;
        branch            = 1'b0;
        reg_w             = 1'b0;
        ir_write          = 1'b0;
        next_pc           = 1'b0;
        ctrl.MemW         = 1'b0;
        ctrl.AdrSrc       = 1'b0;
        ctrl.ResultSrc    = RES_ALUOUT;
        ctrl.ALUSrcA      = 1'b0;
        ctrl.ALUSrcB      = SRCB_RM;
        case (state_q)
            S_FETCH: begin
                state_d        = S_DECODE;
                ir_write       = 1'b1;
                next_pc        = 1'b1;
                ctrl.ALUSrcA   = 1'b1;
                ctrl.ALUSrcB   = SRCB_FOUR;
                ctrl.ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl.ALUSrcA   = 1'b1;
                ctrl.ALUSrcB   = SRCB_FOUR;
                ctrl.ResultSrc = RES_ALURESULT;
                case (ctrl.Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = ctrl.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_d      = ctrl.Funct[0] ? S_MEMREAD : S_MEMWRITE;
                ctrl.ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                state_d     = S_MEMWB;
                ctrl.AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ctrl.ResultSrc = RES_DATA;
                reg_w          = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.AdrSrc = 1'b1;
                ctrl.MemW   = 1'b1;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                alu_op  = 1'b1;
            end
            S_EXECUTEI: begin
                state_d      = S_ALUWB;
                ctrl.ALUSrcB = SRCB_IMM;
                alu_op       = 1'b1;
            end
            S_ALUWB: begin
`ifdef CMP_SUPPORT_EN
                reg_w = (ctrl.Funct[4:1] != CMD_CMP);
`else
                reg_w = 1'b1;
`endif
            end
            S_BRANCH: begin
                ctrl.ALUSrcB   = SRCB_IMM;
                ctrl.ResultSrc = RES_ALURESULT;
                branch         = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State sits in FETCH during reset, so its fetch strobes must be masked.
    assign ctrl.IRWrite = ir_write & RST_N;
    assign ctrl.NextPC  = next_pc & RST_N;
    assign ctrl.RegW    = reg_w;
    assign ctrl.PCS     = (reg_w & (ctrl.Rd == 4'hF)) | branch;
    assign ctrl.ImmSrc  = ctrl.Op;
    assign ctrl.RegSrc  = {ctrl.Op == OP_MEM, ctrl.Op == OP_BR};

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .Funct      (ctrl.Funct[4:0]),
        .ALUControl (ctrl.ALUControl),
        .FlagW      (ctrl.FlagW)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - bench for multicycle_control_fsm against an instruction-level model
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic [1:0] flag_w;
        logic       next_pc;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
    } outs_t;

`ifdef CMP_SUPPORT_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic CLK;
    logic RST_N;
    int   checks = 0;
    int   errors = 0;
    outs_t obs;
    outs_t exp_q[$];

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ctrl  (bus.slave)
    );

    assign obs = {bus.PCS, bus.RegW, bus.MemW, bus.FlagW, bus.NextPC, bus.IRWrite,
                  bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                  bus.ImmSrc, bus.RegSrc};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic outs_t quiet(input logic [1:0] op);
        outs_t o = '0;
        o.imm_src = op;
        o.reg_src = {op == 2'b01, op == 2'b10};
        return o;
    endfunction

    function automatic outs_t fetch_cycle(input logic [1:0] op);
        outs_t o = quiet(op);
        o.ir_write = 1'b1; o.next_pc = 1'b1; o.alu_src_a = 1'b1;
        o.alu_src_b = 2'b10; o.result_src = 2'b10;
        return o;
    endfunction

    function automatic outs_t reset_cycle(input logic [1:0] op);
        outs_t o = fetch_cycle(op);
        o.ir_write = 1'b0; o.next_pc = 1'b0;
        return o;
    endfunction

    function automatic logic [1:0] alu_op_code(input logic [3:0] cmd);
        if (cmd == 4'd4) return 2'd0;
        if (cmd == 4'd2) return 2'd1;
        if (cmd == 4'd0) return 2'd2;
        if (cmd == 4'd12) return 2'd3;
        if (cmd == 4'd10 && CMP_EN) return 2'd1;
        return 2'd0;
    endfunction

    // Expected per-cycle outputs of one whole instruction, fetch included.
    task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd);
        outs_t o;
        logic is_cmp, s;
        exp_q.delete();
        exp_q.push_back(fetch_cycle(op));
        o = quiet(op);
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        exp_q.push_back(o);
        if (op == 2'b01) begin
            o = quiet(op); o.alu_src_b = 2'b01;
            exp_q.push_back(o);
            o = quiet(op); o.adr_src = 1'b1;
            if (funct[0]) begin
                exp_q.push_back(o);
                o = quiet(op); o.result_src = 2'b01; o.reg_w = 1'b1; o.pcs = (rd == 4'd15);
                exp_q.push_back(o);
            end else begin
                o.mem_w = 1'b1;
                exp_q.push_back(o);
            end
        end else if (op == 2'b00) begin
            is_cmp = CMP_EN && (funct[4:1] == 4'd10);
            s = funct[0];
            o = quiet(op);
            o.alu_src_b = funct[5] ? 2'b01 : 2'b00;
            o.alu_control = alu_op_code(funct[4:1]);
            o.flag_w = {s | is_cmp, (s & (o.alu_control < 2'd2)) | is_cmp};
            exp_q.push_back(o);
            o = quiet(op); o.reg_w = !is_cmp; o.pcs = !is_cmp && (rd == 4'd15);
            exp_q.push_back(o);
        end else if (op == 2'b10) begin
            o = quiet(op); o.alu_src_b = 2'b01; o.result_src = 2'b10; o.pcs = 1'b1;
            exp_q.push_back(o);
        end
    endtask

    task automatic check(input outs_t expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                             input int abort_at, input string tag);
        bus.Op = op; bus.Funct = funct; bus.Rd = rd;
        build(op, funct, rd);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge CLK);
            check(exp_q[i], $sformatf("%s[%0d]", tag, i));
            if (i == abort_at) begin
                RST_N = 1'b0;
                #1;
                check(reset_cycle(op), $sformatf("%s_abort", tag));
                for (int k = 0; k < 2; k++) begin
                    @(posedge CLK);
                    @(negedge CLK);
                    checks++;
                    assert (bus.MemW === 1'b0 && bus.RegW === 1'b0) else begin
                        errors++;
                        $error("FAIL %s_abort_hold: observed MemW=%b RegW=%b expected 0", tag, bus.MemW, bus.RegW);
                    end
                    check(reset_cycle(op), $sformatf("%s_abort_hold%0d", tag, k));
                end
                @(posedge CLK);
                #1 RST_N = 1'b1;
                return;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RST_N = 1'b1;
        bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0;
        #2 RST_N = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check(reset_cycle(2'b00), $sformatf("reset%0d", k));
            @(posedge CLK);
        end
        #1 RST_N = 1'b1;

        run_instr(2'b01, 6'b011001, 4'd3,  -1, "ldr");
        run_instr(2'b01, 6'b011000, 4'd2,  -1, "str");
        run_instr(2'b00, 6'b001001, 4'd15, -1, "adds_r15");
        run_instr(2'b00, 6'b111000, 4'd4,  -1, "orr_imm");
        run_instr(2'b10, 6'b101010, 4'd0,  -1, "branch");
        run_instr(2'b11, 6'b000000, 4'd15, -1, "undef");
        run_instr(2'b00, 6'b010101, 4'd15, -1, "cmp");
        run_instr(2'b00, 6'b000101, 4'd1,  -1, "subs");
        run_instr(2'b00, 6'b000001, 4'd1,  -1, "ands");
        run_instr(2'b01, 6'b011001, 4'd15, -1, "ldr_pc");
        run_instr(2'b01, 6'b011000, 4'd5,   2, "str_abort");
        run_instr(2'b00, 6'b001000, 4'd6,  -1, "after_abort");

        for (int n = 0; n < 200; n++) begin
            logic [1:0] op;
            logic [5:0] funct;
            logic [3:0] rd;
            int         ab;
            op    = 2'($urandom_range(0, 3));
            funct = 6'($urandom);
            rd    = 4'($urandom);
            ab    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, funct, rd, ab, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
